ascon_round_ctrl: RTL and testbench
===================================

Name: ascon_round_ctrl

Overview:
- Controller on the driving side of the 4-bit Ascon round counter (ena/init_a/init_b in, count out).
- Runs one permutation (p^a = 12 rounds or p^b = 6 rounds) per start request.
- Drives the counter's ena/init_a/init_b and consumes its count.
- Emits the per-round constant and state-register enable to the permutation datapath, plus busy/done handshake to the top-level FSM.

Parameters:
- LAST_ROUND, 11, count value of the final round for both modes.
- B_START, 6, count value the counter loads on init_b; used by the round check only.
- CONST_W, 8, width of round_const_o.

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  request one permutation; sampled only when ready_o=1
- mode_i  in  1  0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i
- count_i  in  4  current round index from the counter
- cnt_ena_o  out  1  counter enable
- cnt_init_a_o  out  1  counter load 0
- cnt_init_b_o  out  1  counter load B_START
- round_ena_o  out  1  permutation state register update enable
- round_const_o  out  CONST_W  round constant for the current round
- ready_o  out  1  idle, start_i accepted
- busy_o  out  1  permutation in progress
- done_o  out  1  one-cycle pulse after the last round
- err_o  out  1  sticky round-sequence error (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high, overrides all other inputs; applied on the next rising edge of clock_i.
- After reset: state IDLE, ready_o=1, all other outputs 0, captured mode=0.
- States: IDLE, ROUND, DONE. Outputs are Mealy on state, start_i, mode_i and count_i.
- IDLE:
  - ready_o=1.
  - On start_i=1: cnt_ena_o=1 in the same cycle; cnt_init_a_o=~mode_i, cnt_init_b_o=mode_i.
  - Capture mode_i; next state ROUND.
  - start_i=0: all counter outputs 0; stay IDLE.
- ROUND:
  - busy_o=1, round_ena_o=1.
  - round_const_o = {(4'hF - count_i), count_i} (CONST_W=8; upper bits zero if CONST_W>8).
  - Sequence from count 0: F0 E1 D2 C3 B4 A5 96 87 78 69 5A 4B. p^b starts at 96.
  - count_i != LAST_ROUND: cnt_ena_o=1, init outputs 0 (counter increments); stay ROUND.
  - count_i == LAST_ROUND: cnt_ena_o=0 (counter holds at 11); next state DONE.
- DONE:
  - done_o=1, busy_o=0, ready_o=0, round_ena_o=0, round_const_o=0.
  - Next state IDLE unconditionally.
- Latency: start accepted at edge T.
  - p^a: ROUND for cycles T+1..T+12, done_o in cycle T+13.
  - p^b: ROUND for cycles T+1..T+6, done_o in cycle T+7.
  - Next start is accepted in cycle T+14 (p^a) / T+8 (p^b).
- start_i while busy_o=1 or in DONE: ignored, no queuing; mode_i ignored.
- round_const_o=0 and round_ena_o=0 outside ROUND.
- Reset mid-ROUND: return to IDLE next edge; no done_o pulse.
  - The counter is not re-initialised by this block on reset; the next start reloads it.
- count_i > LAST_ROUND in ROUND: the constant is still computed by the formula; the FSM moves to DONE only on equality with LAST_ROUND.
  - Without the check feature, the FSM waits for count_i to wrap around to LAST_ROUND.

Optional Feature:
- Macro: ROUND_CHECK_EN.
- Defined: internal 4-bit shadow counter.
  - Loads 0 (mode 0) or B_START (mode 1) at start acceptance; increments each ROUND cycle while count_i != LAST_ROUND.
  - Any ROUND cycle with count_i != shadow sets err_o=1 and forces next state DONE (done_o still pulses).
  - err_o is sticky; cleared by reset or by the next accepted start.
- Undefined: no shadow counter; err_o tied to 0.

Test Plan:
- Reset: reset_i=1 for 2 cycles, then release -> ready_o=1; busy_o=0, done_o=0, err_o=0, round_const_o=00.
- p^a with the real counter: start_i=1, mode_i=0 at T -> cnt_init_a_o=1 in T; round_const_o F0..4B over T+1..T+12; done_o=1 only in T+13; counter holds 11.
- p^b: start_i=1, mode_i=1 -> cnt_init_b_o=1; constants 96 87 78 69 5A 4B over 6 cycles; done_o in T+7.
- Start during busy: second start_i pulse at T+3 -> ignored; exactly one done_o; ready_o returns in T+14.
- Reset mid-run: reset_i=1 at round 5 -> IDLE next edge, no done_o, round_ena_o=0; new p^b start completes normally.
- ROUND_CHECK_EN defined: drive count_i stuck at 3 during p^a -> err_o=1 on second ROUND cycle, done_o next cycle; err_o clears on next start. Undefined: err_o stays 0.

Source files
------------

// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl: drives the Ascon round counter through one p^a/p^b permutation; define ROUND_CHECK_EN to add a shadow-counter sequence check
module ascon_round_ctrl #(
  parameter int LAST_ROUND = 11,
  parameter int B_START    = 6,
  parameter int CONST_W    = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [3:0]         count_i,
  output logic               cnt_ena_o,
  output logic               cnt_init_a_o,
  output logic               cnt_init_b_o,
  output logic               round_ena_o,
  output logic [CONST_W-1:0] round_const_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [3:0] LAST = 4'(LAST_ROUND);
  state_t state_q, state_d;
  logic last;
  logic [7:0] rc;
  assign last = count_i == LAST;
  assign rc = {4'hF - count_i, count_i};
`ifdef ROUND_CHECK_EN
  localparam logic [3:0] B_ST = 4'(B_START);
  logic [3:0] shadow_q, shadow_d;
  logic err_q, err_d, mis;
  assign mis = state_q == ROUND && count_i != shadow_q;
  assign err_o = err_q | mis;
`else
  assign err_o = 1'b0;
`endif
  // next state and Mealy outputs from state, start/mode and the live count
  always_comb begin
    state_d = state_q;
    cnt_ena_o = 1'b0;
    cnt_init_a_o = 1'b0;
    cnt_init_b_o = 1'b0;
    round_ena_o = 1'b0;
    round_const_o = '0;
    ready_o = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
`ifdef ROUND_CHECK_EN
    shadow_d = shadow_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        cnt_ena_o = start_i;
        cnt_init_a_o = start_i & ~mode_i;
        cnt_init_b_o = start_i & mode_i;
        state_d = start_i ? ROUND : IDLE;
`ifdef ROUND_CHECK_EN
        shadow_d = start_i ? (mode_i ? B_ST : 4'd0) : shadow_q;
        err_d = start_i ? 1'b0 : err_q;
`endif
      end
      ROUND: begin
        busy_o = 1'b1;
        round_ena_o = 1'b1;
        round_const_o = CONST_W'(rc);
        cnt_ena_o = ~last;
        state_d = last ? DONE : ROUND;
`ifdef ROUND_CHECK_EN
        shadow_d = last ? shadow_q : shadow_q + 4'd1;
        err_d = err_q | mis;
        state_d = (last || mis) ? DONE : ROUND;
`endif
      end
      DONE: begin
        done_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset returns to IDLE without touching the counter
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
`ifdef ROUND_CHECK_EN
      shadow_q <= 4'd0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ROUND_CHECK_EN
      shadow_q <= shadow_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_ascon_round_ctrl.sv
// tb_ascon_round_ctrl: scoreboard bench with a model of the 4-bit Ascon round counter
module tb_ascon_round_ctrl;
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic start_i = 1'b0;
  logic mode_i = 1'b0;
  logic [3:0] count_i;
  logic cnt_ena_o, cnt_init_a_o, cnt_init_b_o, round_ena_o, ready_o, busy_o, done_o, err_o;
  logic [7:0] round_const_o;
  logic [3:0] cnt_q = 4'd0;
  logic [3:0] force_v = 4'd0;
  logic force_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [8:0] sb[$];

  ascon_round_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i), .count_i(count_i),
    .cnt_ena_o(cnt_ena_o), .cnt_init_a_o(cnt_init_a_o), .cnt_init_b_o(cnt_init_b_o),
    .round_ena_o(round_ena_o), .round_const_o(round_const_o), .ready_o(ready_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  assign count_i = force_en ? force_v : cnt_q;

  always @(posedge clock_i)
    if (cnt_ena_o) cnt_q <= cnt_init_a_o ? 4'd0 : cnt_init_b_o ? 4'd6 : cnt_q + 4'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic perm(input logic m, input bit dup);
    int t;
    bit seen;
    logic [8:0] e;
    start_i = 1'b1;
    mode_i = m;
    #1;
    check("acc_ready", ready_o, 1);
    check("acc_ena", cnt_ena_o, 1);
    check("acc_init_a", cnt_init_a_o, !m);
    check("acc_init_b", cnt_init_b_o, m);
    for (int i = (m ? 6 : 0); i <= 11; i++) sb.push_back({1'b0, 4'(15 - i), 4'(i)});
    sb.push_back(9'h100);
    seen = 0;
    t = 0;
    while (!seen && t < 20) begin
      tick();
      t++;
      start_i = dup && t == 3;
      mode_i = dup && t == 3;
      #1;
      if (round_ena_o || done_o) begin
        if (sb.size() == 0) check("sb_underflow", {done_o, round_const_o}, 9'h1ff);
        else begin
          e = sb.pop_front();
          check("sb_out", {done_o, round_const_o}, e);
        end
      end
      if (round_ena_o) begin
        check("busy", busy_o, 1);
        check("no_err", err_o, 0);
      end
      if (done_o) begin
        seen = 1;
        check("done_cycle", t, m ? 7 : 13);
        check("done_busy", busy_o, 0);
        check("cnt_hold", count_i, 11);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    start_i = 1'b0;
    mode_i = 1'b0;
    tick();
    check("ready_back", ready_o, 1);
    check("no_extra_done", done_o, 0);
  endtask

  initial begin
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_const", round_const_o, 0);
    check("rst_rena", round_ena_o, 0);
    check("rst_cena", cnt_ena_o, 0);
    perm(1'b0, 1'b0);
    perm(1'b1, 1'b0);
    perm(1'b0, 1'b1);
    start_i = 1'b1;
    mode_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("mid_const", round_const_o, 8'hA5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_rena", round_ena_o, 0);
    tick();
    check("mid_rst_no_done", done_o, 0);
    perm(1'b1, 1'b0);
`ifdef ROUND_CHECK_EN
    start_i = 1'b1;
    mode_i = 1'b0;
    tick();
    start_i = 1'b0;
    #1;
    check("chk_r0_const", round_const_o, 8'hF0);
    check("chk_r0_err", err_o, 0);
    force_v = 4'd3;
    force_en = 1'b1;
    tick();
    check("chk_r1_err", err_o, 1);
    check("chk_r1_const", round_const_o, 8'hC3);
    tick();
    check("chk_done", done_o, 1);
    check("chk_done_err", err_o, 1);
    force_en = 1'b0;
    tick();
    check("chk_sticky", err_o, 1);
    check("chk_idle", ready_o, 1);
    perm(1'b0, 1'b0);
    check("chk_cleared", err_o, 0);
`else
    check("err_tied", err_o, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
